matrix_col_scan: RTL and testbench

Column scan controller for the 5x7 LED matrix. It sits directly upstream of the column decoder and drives its 3-bit column select. It time-multiplexes one column at a time, using a programmable slot length and an anti-ghosting blanking interval. It holds a double-buffered 35-bit frame and drives the matching active-low row pattern for the selected column.

---
 rtl/matrix_col_scan_if.sv | 20 ++
 rtl/matrix_col_scan.sv | 79 +++++++
 tb/tb_matrix_col_scan.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/matrix_col_scan_if.sv
// Bus bundle for the LED matrix column scanner: frame loading and enable in,
// decoder column select, active-low row drive and end-of-frame strobe out.
interface matrix_col_scan_if;
   logic        enable;
   logic        frame_wr;
   logic [34:0] frame_in;
   logic [2:0]  sel;
   logic [6:0]  row_n;
   logic        frame_done;

   modport master (
      output enable, frame_wr, frame_in,
      input  sel, row_n, frame_done
   );

   modport slave (
      input  enable, frame_wr, frame_in,
      output sel, row_n, frame_done
   );
endinterface

// File: rtl/matrix_col_scan.sv
// 5x7 LED matrix column scanner: one column per slot with leading blanking,
// double-buffered frame that only swaps on the last cycle of a frame.
module matrix_col_scan #(
   parameter int DIV      = 50000,
   parameter int BLANK    = 2,
   parameter int NUM_COLS = 5
) (
   input  logic             clk,
   input  logic             reset,
   matrix_col_scan_if.slave bus
);
   localparam int TW = $clog2(DIV);
   localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
   localparam logic [TW-1:0] BLANK_T  = TW'(BLANK);
   localparam logic [2:0]    COL_MAX  = 3'(NUM_COLS - 1);

   logic [TW-1:0] r_tick;
   logic [2:0]    r_col;
   logic          r_en;
   logic [34:0]   r_shadow;
   logic [34:0]   r_active;
   logic          r_pend;

   logic [6:0]    w_col_rows [0:7];
   logic          w_frame_done;
   logic          w_blank;

   // Column slices of the displayed frame; select codes 5..7 never reach the rows.
   for (genvar gi = 0; gi < 8; gi++) begin : g_cols
      if (gi < 5) begin : g_real
         assign w_col_rows[gi] = r_active[7*gi +: 7];
      end else begin : g_pad
         assign w_col_rows[gi] = 7'h00;
      end
   end

   assign w_frame_done = r_en && (r_col == COL_MAX) && (r_tick == TICK_MAX);
   assign w_blank      = (r_tick < BLANK_T);

   assign bus.sel        = (!r_en || w_blank) ? 3'b111 : r_col;
   assign bus.row_n      = (!r_en || w_blank) ? 7'h7F  : ~w_col_rows[r_col];
   assign bus.frame_done = w_frame_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick   <= '0;
         r_col    <= '0;
         r_en     <= 1'b0;
         r_shadow <= '0;
         r_active <= '0;
         r_pend   <= 1'b0;
      end else begin
         r_en <= bus.enable;

         if (!r_en) begin
            r_tick <= '0;
            r_col  <= '0;
         end else if (r_tick == TICK_MAX) begin
            r_tick <= '0;
            r_col  <= (r_col == COL_MAX) ? 3'd0 : r_col + 3'd1;
         end else begin
            r_tick <= r_tick + 1'b1;
         end

         // A write landing on the frame boundary bypasses the shadow wait.
         if (bus.frame_wr && w_frame_done) begin
            r_shadow <= bus.frame_in;
            r_active <= bus.frame_in;
            r_pend   <= 1'b0;
         end else if (bus.frame_wr) begin
            r_shadow <= bus.frame_in;
            r_pend   <= 1'b1;
         end else if (w_frame_done && r_pend) begin
            r_active <= r_shadow;
            r_pend   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_matrix_col_scan.sv
// Self-checking bench for matrix_col_scan with DIV=4, BLANK=1, NUM_COLS=5
// (20-cycle frames); per-cycle expectations go through a scoreboard queue.
module tb_matrix_col_scan;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matrix_col_scan_if bus ();

   matrix_col_scan #(.DIV(4), .BLANK(1), .NUM_COLS(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0] sel;
      logic       done;
   } vec_t;

   typedef struct {
      string      name;
      logic [2:0] sel;
      logic [6:0] row_n;
      logic       done;
   } exp_t;

   vec_t vec [20];
   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [34:0] F1 = 35'h0_0000_007F;
   localparam logic [34:0] F2 = F1 | (35'h2A << 14);
   localparam logic [34:0] F3 = 35'h4_5A3C_96E1;
   localparam logic [34:0] F4 = 35'h3_0F0F_55AA;
   localparam logic [34:0] F5 = 35'h7_FFFF_FFFF;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [34:0] act, input logic [34:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic check_pop();
      exp_t e;
      e = sb.pop_front();
      $display("txn %s: sel=%0d row_n=%02h done=%b", e.name, bus.sel, bus.row_n, bus.frame_done);
      cmp({e.name, ".sel"},   35'(bus.sel),        35'(e.sel));
      cmp({e.name, ".row_n"}, 35'(bus.row_n),      35'(e.row_n));
      cmp({e.name, ".done"},  35'(bus.frame_done), 35'(e.done));
   endtask

   task automatic check_off(input string name);
      exp_t e;
      e.name = name; e.sel = 3'b111; e.row_n = 7'h7F; e.done = 1'b0;
      sb.push_back(e);
      check_pop();
   endtask

   // Checks n cycles of a frame starting at its first cycle; optionally
   // pulses frame_wr on the edge following cycle wr_at.
   task automatic run_frame(input string name, input logic [34:0] fr, input int n,
                            input int wr_at, input logic [34:0] wr_data);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.name = $sformatf("%s[%0d]", name, i);
         e.sel  = vec[i].sel;
         e.done = vec[i].done;
         e.row_n = (vec[i].sel == 3'b111) ? 7'h7F : ~fr[7*int'(vec[i].sel) +: 7];
         sb.push_back(e);
         check_pop();
         if (i == wr_at) begin
            bus.frame_wr = 1'b1;
            bus.frame_in = wr_data;
         end
         step();
         bus.frame_wr = 1'b0;
      end
   endtask

   initial begin
      int sel_tab [20] = '{7,0,0,0, 7,1,1,1, 7,2,2,2, 7,3,3,3, 7,4,4,4};
      for (int i = 0; i < 20; i++) begin
         vec[i].sel  = 3'(sel_tab[i]);
         vec[i].done = (i == 19);
      end

      // Reset dominates enable and frame_wr
      reset = 1'b1;
      bus.enable = 1'b1;
      bus.frame_wr = 1'b1;
      bus.frame_in = '1;
      step();
      step();
      check_off("reset");

      reset = 1'b0;
      bus.enable = 1'b0;
      bus.frame_wr = 1'b0;
      step();
      check_off("disabled");

      // Load while disabled; swap must wait for the first frame end
      bus.frame_wr = 1'b1;
      bus.frame_in = F1;
      step();
      bus.frame_wr = 1'b0;
      check_off("dis_wr");

      bus.enable = 1'b1;
      step();
      run_frame("pre",   35'h0, 20, -1, 35'h0);
      run_frame("row0",  F1,    20,  5, F2);
      run_frame("dbuf",  F2,    20, 19, F3);
      run_frame("coinc", F3,    14, 13, F4);

      // Drop enable inside column 3 with F4 pending
      bus.enable = 1'b0;
      step();
      check_off("en_drop0");
      step();
      check_off("en_drop1");
      bus.enable = 1'b1;
      step();
      run_frame("resume", F3, 20, -1, 35'h0);
      run_frame("swap",   F4,  8,  3, F5);

      // Reset with F5 pending discards it
      reset = 1'b1;
      step();
      check_off("rst_mid");
      reset = 1'b0;
      bus.enable = 1'b0;
      step();
      bus.enable = 1'b1;
      step();
      run_frame("lost0", 35'h0, 20, -1, 35'h0);
      run_frame("lost1", 35'h0, 20, -1, 35'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
